// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 custom-instruction controller.
package lcd_pkg;

  localparam logic [31:0] OP_INIT        = 32'd0;
  localparam logic [31:0] OP_WRITE       = 32'd1;
  localparam logic [31:0] RESULT_INIT    = 32'd1;
  localparam logic [31:0] RESULT_ILLEGAL = 32'hFFFF_FFFF;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT   = 8'h03;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] CMD_FUNC_4BIT  = 8'h28;
  localparam logic [7:0] CMD_FUNC_8BIT  = 8'h38;
  // Bus value of the lone 0x2 nibble that switches the panel into 4-bit mode
  localparam logic [7:0] NIBBLE_ENTER_4BIT = 8'h20;

  typedef enum logic [2:0] {X_IDLE, X_SETUP, X_PULSE, X_HOLD, X_WAIT} xfer_state_t;
  typedef enum logic {C_IDLE, C_BUSY} ctrl_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx, input logic four_bit);
    case (idx)
      2'd0:    init_cmd = four_bit ? CMD_FUNC_4BIT : CMD_FUNC_8BIT;
      2'd1:    init_cmd = CMD_DISPLAY_ON;
      2'd2:    init_cmd = CMD_ENTRY_MODE;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus transfer: SETUP -> PULSE (enable high) -> HOLD -> optional WAIT.
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PW    = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             go,
  input  logic             rs,
  input  logic [7:0]       data,
  input  logic [CNT_W-1:0] wait_len,
  output logic             busy,
  output logic             finished,
  output logic             lcd_rs,
  output logic             lcd_enable,
  output logic [7:0]       lcd_data
);

  localparam int unsigned SETUP_N = (T_SETUP == 0) ? 1 : T_SETUP;
  localparam int unsigned PW_N    = (T_PW == 0) ? 1 : T_PW;
  localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(SETUP_N);
  localparam logic [CNT_W-1:0] PW_LEN    = CNT_W'(PW_N);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  xfer_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_q;

  assign busy = (state != X_IDLE);

  // Last cycle of a transfer; a zero wait length ends the transfer in HOLD.
  always_comb begin
    finished = 1'b0;
    if (state == X_WAIT && cnt == ONE)     finished = 1'b1;
    if (state == X_HOLD && wait_q == '0)   finished = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= X_IDLE;
      cnt        <= '0;
      wait_q     <= '0;
      lcd_rs     <= 1'b0;
      lcd_enable <= 1'b0;
      lcd_data   <= '0;
    end else if (clk_en) begin
      unique case (state)
        X_SETUP: begin
          if (cnt == ONE) begin
            state      <= X_PULSE;
            cnt        <= PW_LEN;
            lcd_enable <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        X_PULSE: begin
          if (cnt == ONE) begin
            state      <= X_HOLD;
            cnt        <= '0;
            lcd_enable <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        X_HOLD: begin
          if (wait_q != '0) begin
            state <= X_WAIT;
            cnt   <= wait_q;
          end
        end
        X_WAIT:  cnt <= cnt - ONE;
        default: ;
      endcase
      // A new go on the final cycle chains straight into the next SETUP.
      if (state == X_IDLE || finished) begin
        if (go) begin
          state    <= X_SETUP;
          cnt      <= SETUP_LEN;
          wait_q   <= wait_len;
          lcd_rs   <= rs;
          lcd_data <= data;
        end else if (finished) begin
          state <= X_IDLE;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_controller.sv
// Nios II custom instruction driving an HD44780 panel: INIT sequence and single-byte WRITE.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PW      = 25,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_LONG    = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_enable,
  output logic [7:0]  lcd_data
);

  localparam bit          FOUR_BIT = (BUS_WIDTH == 4);
  localparam int unsigned CMD_N    = (T_CMD == 0) ? 1 : T_CMD;
  localparam int unsigned LONG_N   = (T_LONG == 0) ? 1 : T_LONG;
  localparam int unsigned MAX_N    = (CMD_N > LONG_N) ? CMD_N : LONG_N;
  localparam int unsigned CNT_W    = ($clog2(MAX_N + 1) > 17) ? $clog2(MAX_N + 1) : 17;
  localparam logic [CNT_W-1:0] CMD_LEN  = CNT_W'(CMD_N);
  localparam logic [CNT_W-1:0] LONG_LEN = CNT_W'(LONG_N);

  ctrl_state_t      cstate;
  logic [3:0]       step;
  logic [3:0]       n_items;
  logic             op_init;
  logic             wr_rs;
  logic [7:0]       wr_byte;
  logic [2:0]       k;
  logic             hi;
  logic [7:0]       cur_byte;
  logic             item_rs;
  logic [7:0]       item_data;
  logic [CNT_W-1:0] item_wait;
  logic             go;
  logic             xfer_busy;
  logic             xfer_finished;
  logic             xfer_ready;
  logic             unused_dataa;

  assign unused_dataa = ^dataa[31:9];
  assign lcd_rw       = 1'b0;

  // Step indexes bus transfers; in 4-bit INIT step 0 is the lone mode-entry nibble.
  always_comb begin
    n_items   = op_init ? (FOUR_BIT ? 4'd9 : 4'd4) : (FOUR_BIT ? 4'd2 : 4'd1);
    k         = op_init ? 3'(step - 4'd1) : step[2:0];
    hi        = ~k[0];
    cur_byte  = wr_byte;
    if (op_init) cur_byte = FOUR_BIT ? init_cmd(k[2:1], 1'b1) : init_cmd(step[1:0], 1'b0);
    item_rs   = op_init ? 1'b0 : wr_rs;
    item_wait = is_long_cmd(item_rs, cur_byte) ? LONG_LEN : CMD_LEN;
    item_data = cur_byte;
    if (FOUR_BIT) begin
      if (op_init && step == 4'd0) begin
        item_data = NIBBLE_ENTER_4BIT;
        item_wait = CMD_LEN;
      end else if (hi) begin
        item_data = {cur_byte[7:4], 4'h0};
        item_wait = '0;
      end else begin
        item_data = {cur_byte[3:0], 4'h0};
      end
    end
  end

  assign xfer_ready = !xfer_busy || xfer_finished;
  assign go         = (cstate == C_BUSY) && xfer_ready && (step < n_items);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cstate  <= C_IDLE;
      step    <= '0;
      op_init <= 1'b0;
      wr_rs   <= 1'b0;
      wr_byte <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (cstate)
        C_IDLE: begin
          if (start && !done) begin
            if (datab == OP_INIT || datab == OP_WRITE) begin
              cstate  <= C_BUSY;
              step    <= '0;
              op_init <= (datab == OP_INIT);
              wr_rs   <= dataa[8];
              wr_byte <= dataa[7:0];
            end else begin
              done   <= 1'b1;
              result <= RESULT_ILLEGAL;
            end
          end
        end
        C_BUSY: begin
          if (go) begin
            step <= step + 4'd1;
          end else if (xfer_finished) begin
            cstate <= C_IDLE;
            done   <= 1'b1;
            result <= op_init ? RESULT_INIT : {23'd0, wr_rs, wr_byte};
          end
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

  lcd_bus_xfer #(
    .CNT_W  (CNT_W),
    .T_SETUP(T_SETUP),
    .T_PW   (T_PW)
  ) u_xfer (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .go        (go),
    .rs        (item_rs),
    .data      (item_data),
    .wait_len  (item_wait),
    .busy      (xfer_busy),
    .finished  (xfer_finished),
    .lcd_rs    (lcd_rs),
    .lcd_enable(lcd_enable),
    .lcd_data  (lcd_data)
  );

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: 8-bit and 4-bit instances with shortened timing.
module tb_lcd_controller;

  typedef struct {
    int         width;
    logic [7:0] data;
    logic       rs;
    int         rise;
    int         fall;
    bit         stable;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic        rst_8 = 1'b0, clk_en_8 = 1'b1, start_8 = 1'b0;
  logic [31:0] dataa_8 = '0, datab_8 = '0;
  logic        done_8, lcd_rs_8, lcd_rw_8, lcd_enable_8;
  logic [31:0] result_8;
  logic [7:0]  lcd_data_8;

  logic        rst_4 = 1'b0, clk_en_4 = 1'b1, start_4 = 1'b0;
  logic [31:0] dataa_4 = '0, datab_4 = '0;
  logic        done_4, lcd_rs_4, lcd_rw_4, lcd_enable_4;
  logic [31:0] result_4;
  logic [7:0]  lcd_data_4;

  lcd_controller #(.BUS_WIDTH(8), .T_SETUP(2), .T_PW(5), .T_CMD(20), .T_LONG(60)) dut8 (
    .clk(clk), .reset(rst_8), .clk_en(clk_en_8), .start(start_8), .dataa(dataa_8), .datab(datab_8),
    .done(done_8), .result(result_8), .lcd_rs(lcd_rs_8), .lcd_rw(lcd_rw_8),
    .lcd_enable(lcd_enable_8), .lcd_data(lcd_data_8));

  lcd_controller #(.BUS_WIDTH(4), .T_SETUP(0), .T_PW(5), .T_CMD(20), .T_LONG(60)) dut4 (
    .clk(clk), .reset(rst_4), .clk_en(clk_en_4), .start(start_4), .dataa(dataa_4), .datab(datab_4),
    .done(done_4), .result(result_4), .lcd_rs(lcd_rs_4), .lcd_rw(lcd_rw_4),
    .lcd_enable(lcd_enable_4), .lcd_data(lcd_data_4));

  pulse_t     pq8[$], pq4[$];
  int         dq8[$], dq4[$];
  logic [31:0] rq8[$], rq4[$];

  int w8, rise8, last8; logic [7:0] cd8; logic crs8; bit st8; logic prev8 = 1'b0;
  always @(negedge clk) begin
    if (lcd_enable_8) begin
      if (!prev8) begin rise8 = cyc; w8 = 0; cd8 = lcd_data_8; crs8 = lcd_rs_8; st8 = 1'b1; end
      if (clk_en_8) w8++;
      if (lcd_data_8 !== cd8 || lcd_rs_8 !== crs8) st8 = 1'b0;
      last8 = cyc;
    end else if (prev8) begin
      pq8.push_back('{w8, cd8, crs8, rise8, last8, st8});
    end
    prev8 = lcd_enable_8;
    if (done_8) begin dq8.push_back(cyc); rq8.push_back(result_8); end
  end

  int w4, rise4, last4; logic [7:0] cd4; logic crs4; bit st4; logic prev4 = 1'b0;
  always @(negedge clk) begin
    if (lcd_enable_4) begin
      if (!prev4) begin rise4 = cyc; w4 = 0; cd4 = lcd_data_4; crs4 = lcd_rs_4; st4 = 1'b1; end
      if (clk_en_4) w4++;
      if (lcd_data_4 !== cd4 || lcd_rs_4 !== crs4) st4 = 1'b0;
      last4 = cyc;
    end else if (prev4) begin
      pq4.push_back('{w4, cd4, crs4, rise4, last4, st4});
    end
    prev4 = lcd_enable_4;
    if (done_4) begin dq4.push_back(cyc); rq4.push_back(result_4); end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [31:0] a, input logic [31:0] b, output int c);
    @(posedge clk); #1;
    dataa_8 = a; datab_8 = b; start_8 = 1'b1; c = cyc;
    @(posedge clk); #1;
    start_8 = 1'b0;
  endtask

  task automatic issue4(input logic [31:0] a, input logic [31:0] b, output int c);
    @(posedge clk); #1;
    dataa_4 = a; datab_4 = b; start_4 = 1'b1; c = cyc;
    @(posedge clk); #1;
    start_4 = 1'b0;
  endtask

  task automatic wait_done8(input int nd, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (dq8.size() > nd) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done4(input int nd, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (dq4.size() > nd) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_enable8(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (lcd_enable_8) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({done_8, result_8, lcd_rs_8, lcd_rw_8, lcd_enable_8, lcd_data_8} !== '0)
      $display("FAIL reset8_outputs: got done=%b result=%h rs=%b rw=%b en=%b data=%h, expected all 0",
               done_8, result_8, lcd_rs_8, lcd_rw_8, lcd_enable_8, lcd_data_8);
    else passes++;
    checks++;
    if ({done_4, result_4, lcd_rs_4, lcd_rw_4, lcd_enable_4, lcd_data_4} !== '0)
      $display("FAIL reset4_outputs: got done=%b result=%h rs=%b rw=%b en=%b data=%h, expected all 0",
               done_4, result_4, lcd_rs_4, lcd_rw_4, lcd_enable_4, lcd_data_4);
    else passes++;
    @(posedge clk); #1;
    rst_8 = 1'b1; rst_4 = 1'b1;
    tick(30);
    checks++;
    if (pq8.size() + dq8.size() + pq4.size() + dq4.size() != 0)
      $display("FAIL no_auto_init: got pulses8=%0d done8=%0d pulses4=%0d done4=%0d, expected 0",
               pq8.size(), dq8.size(), pq4.size(), dq4.size());
    else passes++;
  endtask

  task automatic test_init8();
    logic [7:0] exp [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int n, nd, c; bit ok;
    n = pq8.size(); nd = dq8.size();
    issue8(32'h0, 32'h0, c);
    wait_done8(nd, 2000, ok);
    tick(5);
    checks++;
    if (pq8.size() - n != 4) $display("FAIL init8_count: got %0d pulses, expected 4", pq8.size() - n);
    else passes++;
    if (pq8.size() - n == 4) begin
      checks++;
      if (pq8[n].rise - c != 4) $display("FAIL init8_latency: got %0d, expected 4", pq8[n].rise - c);
      else passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pq8[n+i].data !== exp[i] || pq8[n+i].rs !== 1'b0 || pq8[n+i].width != 5 || !pq8[n+i].stable)
          $display("FAIL init8_pulse%0d: got data=%h rs=%b width=%0d stable=%0d, expected data=%h rs=0 width=5 stable=1",
                   i, pq8[n+i].data, pq8[n+i].rs, pq8[n+i].width, pq8[n+i].stable, exp[i]);
        else passes++;
        if (i > 0) begin
          checks++;
          if (pq8[n+i].rise - pq8[n+i-1].fall != 24)
            $display("FAIL init8_gap%0d: got %0d, expected 24", i, pq8[n+i].rise - pq8[n+i-1].fall);
          else passes++;
        end
      end
      if (ok) begin
        checks++;
        if (dq8[nd] - pq8[n+3].fall != 62)
          $display("FAIL init8_long_wait: got %0d, expected 62", dq8[nd] - pq8[n+3].fall);
        else passes++;
      end
    end
    checks++;
    if (!ok || rq8[nd] !== 32'd1) $display("FAIL init8_result: got ok=%0d result=%h, expected 00000001", ok, ok ? rq8[nd] : 32'hx);
    else passes++;
    checks++;
    if (dq8.size() - nd != 1) $display("FAIL init8_done_once: got %0d done cycles, expected 1", dq8.size() - nd);
    else passes++;
  endtask

  task automatic test_init4();
    logic [7:0] exp [9] = '{8'h20, 8'h20, 8'h80, 8'h00, 8'hC0, 8'h00, 8'h60, 8'h00, 8'h10};
    int gap [8] = '{23, 3, 23, 3, 23, 3, 23, 3};
    int n, nd, c; bit ok;
    n = pq4.size(); nd = dq4.size();
    issue4(32'h0, 32'h0, c);
    wait_done4(nd, 3000, ok);
    tick(5);
    checks++;
    if (pq4.size() - n != 9) $display("FAIL init4_count: got %0d pulses, expected 9", pq4.size() - n);
    else passes++;
    if (pq4.size() - n == 9) begin
      checks++;
      if (pq4[n].rise - c != 3) $display("FAIL init4_latency: got %0d, expected 3", pq4[n].rise - c);
      else passes++;
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (pq4[n+i].data !== exp[i] || pq4[n+i].rs !== 1'b0 || pq4[n+i].width != 5 || !pq4[n+i].stable)
          $display("FAIL init4_pulse%0d: got data=%h rs=%b width=%0d stable=%0d, expected data=%h rs=0 width=5 stable=1",
                   i, pq4[n+i].data, pq4[n+i].rs, pq4[n+i].width, pq4[n+i].stable, exp[i]);
        else passes++;
        if (i < 8) begin
          checks++;
          if (pq4[n+i+1].rise - pq4[n+i].fall != gap[i])
            $display("FAIL init4_gap%0d: got %0d, expected %0d", i, pq4[n+i+1].rise - pq4[n+i].fall, gap[i]);
          else passes++;
        end
      end
      if (ok) begin
        checks++;
        if (dq4[nd] - pq4[n+8].fall != 62)
          $display("FAIL init4_long_wait: got %0d, expected 62", dq4[nd] - pq4[n+8].fall);
        else passes++;
      end
    end
    checks++;
    if (!ok || rq4[nd] !== 32'd1) $display("FAIL init4_result: got ok=%0d result=%h, expected 00000001", ok, ok ? rq4[nd] : 32'hx);
    else passes++;
  endtask

  task automatic test_write4();
    int n, nd, c; bit ok;
    n = pq4.size(); nd = dq4.size();
    issue4(32'h141, 32'h1, c);
    wait_done4(nd, 500, ok);
    tick(3);
    checks++;
    if (pq4.size() - n != 2) $display("FAIL write4_count: got %0d pulses, expected 2", pq4.size() - n);
    else passes++;
    if (pq4.size() - n == 2) begin
      checks++;
      if (pq4[n].data !== 8'h40 || pq4[n+1].data !== 8'h10 || pq4[n].rs !== 1'b1 || pq4[n+1].rs !== 1'b1)
        $display("FAIL write4_nibbles: got %h/%b then %h/%b, expected 40/1 then 10/1",
                 pq4[n].data, pq4[n].rs, pq4[n+1].data, pq4[n+1].rs);
      else passes++;
      checks++;
      if (pq4[n+1].rise - pq4[n].fall != 3)
        $display("FAIL write4_nibble_gap: got %0d, expected 3", pq4[n+1].rise - pq4[n].fall);
      else passes++;
      if (ok) begin
        checks++;
        if (dq4[nd] - pq4[n+1].fall != 22)
          $display("FAIL write4_wait: got %0d, expected 22", dq4[nd] - pq4[n+1].fall);
        else passes++;
      end
    end
    checks++;
    if (!ok || rq4[nd] !== 32'h141) $display("FAIL write4_result: got ok=%0d result=%h, expected 00000141", ok, ok ? rq4[nd] : 32'hx);
    else passes++;
  endtask

  task automatic test_clk_en_pause();
    int n, nd, c; bit ok, en_ok;
    n = pq8.size(); nd = dq8.size();
    issue8(32'h155, 32'h1, c);
    wait_enable8(50, en_ok);
    tick(1);
    clk_en_8 = 1'b0;
    tick(100);
    checks++;
    if (lcd_enable_8 !== 1'b1 || pq8.size() != n || !en_ok)
      $display("FAIL pause_enable_held: got en=%b pulses=%0d, expected en=1 pulses=0", lcd_enable_8, pq8.size() - n);
    else passes++;
    clk_en_8 = 1'b1;
    wait_done8(nd, 500, ok);
    tick(3);
    checks++;
    if (pq8.size() - n != 1) $display("FAIL pause_count: got %0d pulses, expected 1", pq8.size() - n);
    else passes++;
    if (pq8.size() - n == 1) begin
      checks++;
      if (pq8[n].width != 5 || pq8[n].data !== 8'h55 || pq8[n].rs !== 1'b1)
        $display("FAIL pause_pulse: got width=%0d data=%h rs=%b, expected width=5 data=55 rs=1",
                 pq8[n].width, pq8[n].data, pq8[n].rs);
      else passes++;
      if (ok) begin
        checks++;
        if (dq8[nd] - pq8[n].fall != 22) $display("FAIL pause_wait: got %0d, expected 22", dq8[nd] - pq8[n].fall);
        else passes++;
      end
    end
    checks++;
    if (!ok || rq8[nd] !== 32'h155) $display("FAIL pause_result: got ok=%0d result=%h, expected 00000155", ok, ok ? rq8[nd] : 32'hx);
    else passes++;
  endtask

  task automatic test_illegal();
    int n, nd, c; bit ok;
    n = pq8.size(); nd = dq8.size();
    issue8(32'h0, 32'h7, c);
    wait_done8(nd, 10, ok);
    tick(20);
    checks++;
    if (!ok || dq8[nd] != c + 1) $display("FAIL illegal_done_cycle: got ok=%0d at +%0d, expected +1", ok, ok ? dq8[nd] - c : -1);
    else passes++;
    checks++;
    if (!ok || rq8[nd] !== 32'hFFFF_FFFF) $display("FAIL illegal_result: got %h, expected ffffffff", ok ? rq8[nd] : 32'hx);
    else passes++;
    checks++;
    if (pq8.size() != n || dq8.size() - nd != 1)
      $display("FAIL illegal_quiet: got pulses=%0d dones=%0d, expected 0 and 1", pq8.size() - n, dq8.size() - nd);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n, nd, n4, nd4, c; bit ok, en_ok;
    n = pq8.size(); nd = dq8.size();
    issue8(32'h0, 32'h0, c);
    wait_enable8(50, en_ok);
    tick(2);
    #2; rst_8 = 1'b0; #1;
    checks++;
    if (!en_ok || {lcd_enable_8, lcd_rs_8, lcd_data_8, done_8, result_8} !== '0)
      $display("FAIL reset_mid_pulse: got en=%b rs=%b data=%h done=%b result=%h, expected all 0",
               lcd_enable_8, lcd_rs_8, lcd_data_8, done_8, result_8);
    else passes++;
    @(posedge clk); #1; rst_8 = 1'b1;

    n4 = pq4.size(); nd4 = dq4.size();
    issue4(32'h0, 32'h0, c);
    for (int i = 0; i < 50 && pq4.size() == n4; i++) tick(1);
    tick(3);
    #2; rst_4 = 1'b0; #1;
    checks++;
    if (pq4.size() != n4 + 1 || {lcd_enable_4, lcd_rs_4, lcd_data_4, done_4, result_4} !== '0)
      $display("FAIL reset_mid_wait: got pulses=%0d en=%b rs=%b data=%h done=%b result=%h, expected 1 and all 0",
               pq4.size() - n4, lcd_enable_4, lcd_rs_4, lcd_data_4, done_4, result_4);
    else passes++;
    @(posedge clk); #1; rst_4 = 1'b1;
    tick(150);
    checks++;
    if (dq8.size() != nd || pq8.size() != n + 1 || dq4.size() != nd4 || pq4.size() != n4 + 1)
      $display("FAIL reset_abort: got done8=%0d pulses8=%0d done4=%0d pulses4=%0d, expected 0 1 0 1",
               dq8.size() - nd, pq8.size() - n, dq4.size() - nd4, pq4.size() - n4);
    else passes++;

    n = pq8.size();
    issue8(32'h002, 32'h1, c);
    wait_done8(nd, 500, ok);
    tick(3);
    checks++;
    if (pq8.size() - n != 1 || !ok) $display("FAIL after_reset_write: got pulses=%0d ok=%0d, expected 1 and 1", pq8.size() - n, ok);
    else passes++;
    if (pq8.size() - n == 1 && ok) begin
      checks++;
      if (pq8[n].data !== 8'h02 || pq8[n].rs !== 1'b0 || dq8[nd] - pq8[n].fall != 62 || rq8[nd] !== 32'h002)
        $display("FAIL home_long_wait: got data=%h rs=%b wait=%0d result=%h, expected 02 0 62 00000002",
                 pq8[n].data, pq8[n].rs, dq8[nd] - pq8[n].fall, rq8[nd]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int n, nd, c, d; bit ok, en_ok;
    n = pq8.size(); nd = dq8.size();
    issue8(32'h1AB, 32'h1, c);
    wait_enable8(50, en_ok);
    dataa_8 = 32'h0CD; datab_8 = 32'h1; start_8 = 1'b1;
    tick(3);
    start_8 = 1'b0;
    for (int i = 0; i < 50 && pq8.size() == n; i++) tick(1);
    d = (pq8.size() > n) ? pq8[n].fall + 22 : cyc;
    for (int i = 0; i < 100 && cyc < d; i++) tick(1);
    dataa_8 = 32'h0CD; datab_8 = 32'h0; start_8 = 1'b1;
    tick(1);
    start_8 = 1'b0;
    tick(80);
    checks++;
    if (!en_ok || dq8.size() - nd != 1 || dq8[nd] != d)
      $display("FAIL busy_single_done: got dones=%0d first=%0d, expected 1 at %0d",
               dq8.size() - nd, (dq8.size() > nd) ? dq8[nd] : -1, d);
    else passes++;
    checks++;
    if (pq8.size() - n != 1 || pq8[n].data !== 8'hAB || lcd_data_8 !== 8'hAB)
      $display("FAIL busy_start_ignored: got pulses=%0d bus=%h, expected 1 and ab", pq8.size() - n, lcd_data_8);
    else passes++;
    checks++;
    if (dq8.size() <= nd || rq8[nd] !== 32'h1AB)
      $display("FAIL busy_result: got %h, expected 000001ab", (dq8.size() > nd) ? rq8[nd] : 32'hx);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_init8();
    test_init4();
    test_write4();
    test_clk_en_pause();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
